// File: rtl/flap_controller.sv
// Game sequencer for the 16-light bird column: flap/gravity pulses, death detection, scoring.
// Optional key cooldown after each flap is built when FLAP_COOLDOWN_EN is defined.
module flap_controller #(
  parameter int unsigned FALL_PERIOD = 12500000,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned COOLDOWN    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               start,
  input  logic [15:0]        lights,
  input  logic               pipe_hit,
  input  logic               pipe_pass,
  output logic               push,
  output logic               fall,
  output logic               bird_reset,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  // state | meaning
  // IDLE  | column held in reset, waiting for start
  // PLAY  | game running, pulses and scoring active
  // DEAD  | game over, column image frozen, waiting for start
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;

  localparam int unsigned      TICK_W    = (FALL_PERIOD > 2) ? $clog2(FALL_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FALL_PERIOD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               key_q, start_q;
  logic               push_q, push_d;
  logic               fall_q, fall_d;
  logic               bird_reset_q, bird_reset_d;
  logic               playing_q, playing_d;
  logic               game_over_q, game_over_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic key_rise, start_rise, key_ok, term_cnt, push_ok, fall_ok, die;

  assign key_rise   = key & ~key_q;
  assign start_rise = start & ~start_q;
  assign term_cnt   = (tick_q == TICK_LAST);
  assign push_ok    = key_ok;
  // A flap restarts the gravity period, so it always wins over a coincident fall.
  assign fall_ok    = term_cnt & ~push_ok;
  assign die        = pipe_hit
                    | (push_ok & lights[0])
                    | (fall_ok & lights[15])
                    | (lights == 16'h0000);

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    push_d       = 1'b0;
    fall_d       = 1'b0;
    bird_reset_d = bird_reset_q;
    score_d      = score_q;
    case (state_q)
      IDLE: begin
        tick_d       = '0;
        bird_reset_d = 1'b1;
        if (start_rise) begin
          state_d      = PLAY;
          score_d      = '0;
          bird_reset_d = 1'b0;
        end
      end
      PLAY: begin
        bird_reset_d = 1'b0;
        if (die) begin
          state_d = DEAD;
          tick_d  = '0;
        end else begin
          push_d = push_ok;
          fall_d = fall_ok;
          tick_d = (push_ok || term_cnt) ? '0 : tick_q + 1'b1;
          if (pipe_pass && (score_q != SCORE_MAX)) begin
            score_d = score_q + 1'b1;
          end
        end
      end
      DEAD: begin
        tick_d       = '0;
        bird_reset_d = 1'b0;
        if (start_rise) begin
          state_d      = IDLE;
          bird_reset_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        tick_d       = '0;
        bird_reset_d = 1'b1;
      end
    endcase
    playing_d   = (state_d == PLAY);
    game_over_d = (state_d == DEAD);
  end

`ifdef FLAP_COOLDOWN_EN
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

  logic [COOL_W-1:0] cool_q, cool_d;

  assign key_ok = key_rise & (cool_q == '0);

  always_comb begin
    cool_d = '0;
    if ((state_q == PLAY) && (state_d == PLAY)) begin
      if (push_d) begin
        cool_d = COOL_W'(COOLDOWN);
      end else if (cool_q != '0) begin
        cool_d = cool_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cool_q <= '0;
    end else begin
      cool_q <= cool_d;
    end
  end
`else
  localparam int unsigned UNUSED_COOLDOWN = COOLDOWN;

  assign key_ok = key_rise;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      key_q        <= 1'b0;
      start_q      <= 1'b0;
      push_q       <= 1'b0;
      fall_q       <= 1'b0;
      bird_reset_q <= 1'b1;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      key_q        <= key;
      start_q      <= start;
      push_q       <= push_d;
      fall_q       <= fall_d;
      bird_reset_q <= bird_reset_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
      score_q      <= score_d;
    end
  end

  assign push       = push_q;
  assign fall       = fall_q;
  assign bird_reset = bird_reset_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign score      = score_q;

endmodule

// File: tb/tb_flap_controller.sv
// Directed bench for flap_controller with FALL_PERIOD=4, SCORE_W=2, COOLDOWN=4.
module tb_flap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        key;
  logic        start;
  logic [15:0] lights;
  logic        pipe_hit;
  logic        pipe_pass;
  logic        push;
  logic        fall;
  logic        bird_reset;
  logic        playing;
  logic        game_over;
  logic [1:0]  score;

  int errors = 0;
  int checks = 0;

  flap_controller #(
    .FALL_PERIOD(4),
    .SCORE_W    (2),
    .COOLDOWN   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .start     (start),
    .lights    (lights),
    .pipe_hit  (pipe_hit),
    .pipe_pass (pipe_pass),
    .push      (push),
    .fall      (fall),
    .bird_reset(bird_reset),
    .playing   (playing),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_score[4] = '{1, 2, 3, 3};

  initial begin
    reset = 1'b1; key = 1'b0; start = 1'b0; lights = 16'h0100;
    pipe_hit = 1'b0; pipe_pass = 1'b0;
    #1 reset = 1'b0;
    step(); step();
    check("rst_push", push, 0);
    check("rst_fall", fall, 0);
    check("rst_bird_reset", bird_reset, 1);
    check("rst_playing", playing, 0);
    check("rst_game_over", game_over, 0);
    check("rst_score", score, 0);

    reset = 1'b1;
    step();
    check("idle_bird_reset", bird_reset, 1);
    check("idle_playing", playing, 0);

    // start rise -> PLAY cycle 0, tick 0
    start = 1'b1;
    step();
    check("play_entry_playing", playing, 1);
    check("play_entry_bird_reset", bird_reset, 0);
    check("play_entry_score", score, 0);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("period_fall_c%0d", i), fall, (i % 4 == 0) ? 1 : 0);
      check($sformatf("period_push_c%0d", i), push, 0);
    end

    // key held 10 cycles: single push, fall 4 cycles after it
    key = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      check($sformatf("hold_push_%0d", j), push, (j == 1) ? 1 : 0);
      check($sformatf("hold_fall_%0d", j), fall, (j == 5 || j == 9) ? 1 : 0);
    end
    key = 1'b0;
    step();
    step();
    check("pre_tc_fall", fall, 0);

    // key rise lands on terminal count
    key = 1'b1;
    step();
    check("coinc_push", push, 1);
    check("coinc_fall", fall, 0);
    key = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("coinc_next_fall_%0d", k), fall, (k == 4) ? 1 : 0);
    end

    for (int p = 0; p < 4; p++) begin
      pipe_pass = 1'b1;
      step();
      pipe_pass = 1'b0;
      check($sformatf("score_%0d", p), score, exp_score[p]);
      step();
    end

    pipe_hit = 1'b1;
    step();
    pipe_hit = 1'b0;
    check("hit_game_over", game_over, 1);
    check("hit_playing", playing, 0);
    check("hit_bird_reset", bird_reset, 0);
    pipe_pass = 1'b1;
    step();
    pipe_pass = 1'b0;
    check("dead_score_frozen", score, 3);
    check("dead_push", push, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_idle_bird_reset", bird_reset, 1);
    check("restart_idle_game_over", game_over, 0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_play_score", score, 0);
    check("restart_playing", playing, 1);

    // bottom exit at terminal count
    step(); step(); step();
    lights = 16'h8000;
    step();
    lights = 16'h0100;
    check("bottom_fall_suppressed", fall, 0);
    check("bottom_game_over", game_over, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("bottom_restart_bird_reset", bird_reset, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("top_setup_playing", playing, 1);

    // top exit on push
    lights = 16'h0001;
    key = 1'b1;
    step();
    key = 1'b0;
    lights = 16'h0100;
    check("top_push_suppressed", push, 0);
    check("top_game_over", game_over, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;

    lights = 16'h0000;
    step();
    lights = 16'h0100;
    check("dark_game_over", game_over, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("cool_setup_playing", playing, 1);

    // push, then rises 2 and 5 cycles after it
    key = 1'b1;
    step();
    check("cool_first_push", push, 1);
    key = 1'b0;
    step();
    key = 1'b1;
    step();
`ifdef FLAP_COOLDOWN_EN
    check("cool_rise2_push", push, 0);
`else
    check("cool_rise2_push", push, 1);
`endif
    key = 1'b0;
    step();
    check("cool_c4_push", push, 0);
    step();
    check("cool_c5_push", push, 0);
    key = 1'b1;
    step();
    check("cool_rise5_push", push, 1);

    // async reset mid-cycle while push is high
    #2 reset = 1'b0;
    #1;
    check("async_push", push, 0);
    check("async_fall", fall, 0);
    check("async_bird_reset", bird_reset, 1);
    check("async_playing", playing, 0);
    check("async_game_over", game_over, 0);
    check("async_score", score, 0);
    key = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("post_reset_playing", playing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flap_controller.md
Name: flap_controller

Overview:
Game sequencer for the 16-light bird column. It turns the player key into single-cycle push pulses and generates periodic gravity fall pulses. It drives the column's active-high reset, monitors the column for boundary deaths and pipe collisions, and keeps the score. It sits between the input synchronizers / pipe logic and the bird column.

Parameters:
FALL_PERIOD, 12500000, clock cycles between gravity fall pulses (>=2)
SCORE_W, 8, score counter width
COOLDOWN, 4, cycles a key edge is ignored after a push (used only with FLAP_COOLDOWN_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
key  input  1  flap request level, already synchronized to clk
start  input  1  start/restart request level, already synchronized
lights  input  16  bird column state fed back; lights[0] top, lights[15] bottom
pipe_hit  input  1  level: pipe occupies the bird's row in the bird column
pipe_pass  input  1  one-cycle pulse: pipe has cleared the bird column
push  output  1  one-cycle flap pulse to the column
fall  output  1  one-cycle gravity pulse to the column
bird_reset  output  1  active-high reset to the column (reload start position, lights[8])
playing  output  1  high in PLAY
game_over  output  1  high in DEAD
score  output  SCORE_W  pipes passed this game

Behaviour:
- Reset (reset==0, async): state=IDLE; push=0, fall=0, bird_reset=1, playing=0, game_over=0, score=0; tick counter=0; edge-detect registers=0.
- Edge detect: key_rise / start_rise = input sampled 1 at this edge and 0 at the previous edge. All outputs are registered.
- IDLE: bird_reset=1, push=fall=0; tick counter held at 0. start_rise -> PLAY; score cleared on this transition. bird_reset=0 from the first PLAY cycle.
- PLAY: tick counter runs 0..FALL_PERIOD-1, then wraps to 0.
  - Terminal count -> fall=1 for exactly the next cycle.
  - key_rise at edge N -> push=1 during cycle N+1 only; one push per rise. Key held high never repeats.
  - Simultaneous key_rise and terminal count: push wins, fall suppressed, counter restarts at 0.
  - pipe_pass -> score+1 next cycle, saturating at 2^SCORE_W-1.
- Death (from PLAY, checked every cycle; -> DEAD next cycle; the triggering push/fall is suppressed):
  - pipe_hit==1;
  - a push would issue while lights[0]==1 (top exit);
  - a fall would issue while lights[15]==1 (bottom exit);
  - lights==16'h0000 (no bird lit; fault).
- DEAD: game_over=1, playing=0, push=fall=0, score frozen, bird_reset=0 (final column image kept). start_rise -> IDLE.
- A start_rise in PLAY is ignored. key_rise in IDLE or DEAD is ignored.
- Reset mid-game: returns to IDLE immediately, asynchronously; no pulse emitted after reset asserts.
- push and fall are never high in the same cycle.

Optional Feature:
FLAP_COOLDOWN_EN:
- Defined: after a push, a cooldown counter loads COOLDOWN; key_rise is discarded while the counter is nonzero. The counter decrements every PLAY cycle and clears on leaving PLAY.
- Undefined: every key_rise in PLAY issues a push; no counter is synthesized.

Test Plan:
- Reset then release, start rises, FALL_PERIOD=4 -> bird_reset 1 until first PLAY cycle, then 0; fall pulses exactly every 4 cycles; push stays 0.
- PLAY, key held high for 10 cycles -> exactly one push, in the cycle after the rise; fall resumes 4 cycles after that push.
- key_rise coincident with terminal count -> push=1, fall=0 that cycle; next fall 4 cycles later.
- lights=16'h8000 at terminal count -> no fall pulse, game_over=1 next cycle. Then start rises -> IDLE, bird_reset=1.
- 3 pipe_pass pulses in PLAY, SCORE_W=2, then 1 more -> score 1,2,3,3. pipe_hit=1 -> DEAD, score stays 3. Restart to PLAY -> score 0.
- FLAP_COOLDOWN_EN, COOLDOWN=4: key rises 2 cycles after a push -> ignored; key rises 5 cycles after the push -> push issued. reset low mid-PLAY -> all outputs at reset values within the same cycle.
